// File: rtl/regfile_scoreboard_pkg.sv
// Shared pipeline constants for the register file and its load scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback signal bundle between the pipeline and the register file.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              RegWriteW;
  logic [ADDR_W-1:0] RdW;
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] A1D;
  logic [ADDR_W-1:0] A2D;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic              PendSetD;
  logic [ADDR_W-1:0] RdD;
  logic              FlushE;
  logic              StallD;
  logic [ADDR_W:0]   PendCount;

  modport master (
    output RegWriteW, RdW, ResultW, A1D, A2D, PendSetD, RdD, FlushE,
    input  RD1D, RD2D, StallD, PendCount
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, A1D, A2D, PendSetD, RdD, FlushE,
    output RD1D, RD2D, StallD, PendCount
  );

endinterface

// File: rtl/regfile_scoreboard_pending_table.sv
// Per-register pending bits for late (load) results, with flush of the last issue.
module pending_table
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_idx,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_idx,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_a1,
  input  logic [ADDR_W-1:0] i_a2,
  output logic              o_stall,
  output logic [ADDR_W:0]   o_pend_count
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX0 = ADDR_W'(REG_ZERO);

  logic [NREG-1:0]   r_pend;
  logic              r_last_vld;
  logic [ADDR_W-1:0] r_last_idx;
  logic [ADDR_W:0]   r_count;

  logic [NREG-1:0]   w_pend_nxt;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_set_ok;
  logic              w_stall1;
  logic              w_stall2;

  assign w_set_ok = i_set && (i_set_idx != IDX0);

  // Set is applied last so a same-cycle issue beats both writeback and flush.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr)
      w_pend_nxt[i_clr_idx] = 1'b0;
    if (i_flush && r_last_vld)
      w_pend_nxt[r_last_idx] = 1'b0;
    if (w_set_ok)
      w_pend_nxt[i_set_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++)
      w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i[ADDR_W-1:0]]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_last_vld <= 1'b0;
      r_last_idx <= '0;
      r_count    <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_last_vld <= w_set_ok;
      r_last_idx <= i_set_idx;
      r_count    <= w_count_nxt;
    end
  end

  assign w_stall1 = (i_a1 != IDX0) && r_pend[i_a1] && !(i_clr && (i_clr_idx == i_a1));
  assign w_stall2 = (i_a2 != IDX0) && r_pend[i_a2] && !(i_clr && (i_clr_idx == i_a2));

  assign o_stall      = w_stall1 || w_stall2;
  assign o_pend_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle writeback bypass and a load-pending scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_stall;
  logic [ADDR_W:0]   w_pend_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_regs <= '{default: '0};
    else if (bus.RegWriteW && (bus.RdW != IDX0))
      r_regs[bus.RdW] <= bus.ResultW;
  end

  always_comb begin
    w_rd1 = r_regs[bus.A1D];
    if (bus.RegWriteW && (bus.RdW == bus.A1D))
      w_rd1 = bus.ResultW;
    if (bus.A1D == IDX0)
      w_rd1 = '0;

    w_rd2 = r_regs[bus.A2D];
    if (bus.RegWriteW && (bus.RdW == bus.A2D))
      w_rd2 = bus.ResultW;
    if (bus.A2D == IDX0)
      w_rd2 = '0;
  end

  pending_table #(
    .ADDR_W (ADDR_W)
  ) u_pending_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set        (bus.PendSetD),
    .i_set_idx    (bus.RdD),
    .i_clr        (bus.RegWriteW),
    .i_clr_idx    (bus.RdW),
    .i_flush      (bus.FlushE),
    .i_a1         (bus.A1D),
    .i_a2         (bus.A2D),
    .o_stall      (w_stall),
    .o_pend_count (w_pend_count)
  );

  assign bus.RD1D      = w_rd1;
  assign bus.RD2D      = w_rd2;
  assign bus.StallD    = w_stall;
  assign bus.PendCount = w_pend_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: every-cycle model compare plus literal checks.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Architectural model: register contents, set of pending registers, last issued load.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_last_vld;
  int            m_last_idx;
  int            m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      m_last_vld = 0;
      m_last_idx = 0;
      m_count    = 0;
    end else begin
      if (bus.RegWriteW && bus.RdW != 0) m_regs[bus.RdW] = bus.ResultW;
      if (bus.RegWriteW) m_pend[bus.RdW] = 0;
      if (bus.FlushE && m_last_vld) m_pend[m_last_idx] = 0;
      if (bus.PendSetD && bus.RdD != 0) m_pend[bus.RdD] = 1;
      m_pend[0]  = 0;
      m_last_vld = bus.PendSetD && (bus.RdD != 0);
      m_last_idx = int'(bus.RdD);
      m_count = 0;
      for (int i = 0; i < NR; i++) m_count += int'(m_pend[i]);
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int idx);
    if (idx == 0) return '0;
    if (bus.RegWriteW && int'(bus.RdW) == idx) return bus.ResultW;
    return m_regs[idx];
  endfunction

  function automatic bit exp_src_stall(input int idx);
    return (idx != 0) && m_pend[idx] && !(bus.RegWriteW && int'(bus.RdW) == idx);
  endfunction

  always @(negedge clk) begin
    chk("model_rd1", bus.RD1D, exp_rd(int'(bus.A1D)));
    chk("model_rd2", bus.RD2D, exp_rd(int'(bus.A2D)));
    chk("model_stall", bus.StallD,
        exp_src_stall(int'(bus.A1D)) || exp_src_stall(int'(bus.A2D)));
    chk("model_count", bus.PendCount, m_count);
  end

  task automatic idle();
    bus.RegWriteW = 1'b0;
    bus.RdW       = '0;
    bus.ResultW   = '0;
    bus.A1D       = '0;
    bus.A2D       = '0;
    bus.PendSetD  = 1'b0;
    bus.RdD       = '0;
    bus.FlushE    = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] val);
    bus.RegWriteW = 1'b1;
    bus.RdW       = AW'(idx);
    bus.ResultW   = val;
  endtask

  task automatic pset(input int idx);
    bus.PendSetD = 1'b1;
    bus.RdD      = AW'(idx);
  endtask

  initial begin
    idle();
    #2;
    chk("reset_count", bus.PendCount, 0);
    chk("reset_stall", bus.StallD, 0);
    chk("reset_rd1", bus.RD1D, 0);
    #10 rst_n = 1'b1;
    cyc();

    // Write then read back next cycle; same-cycle bypass on port 2
    wr(5, 32'h0000_00AA);
    cyc();
    bus.A1D = 5'd5;
    wr(6, 32'h0000_1234);
    bus.A2D = 5'd6;
    #3;
    chk("rd_after_write", bus.RD1D, 32'h0000_00AA);
    chk("bypass_rd2", bus.RD2D, 32'h0000_1234);
    cyc();

    // Register zero
    wr(0, 32'hFFFF_FFFF);
    #3 chk("x0_bypass_blocked", bus.RD1D, 0);
    cyc();
    pset(0);
    cyc();
    #3 chk("x0_never_pending", bus.PendCount, 0);
    cyc();

    // Load pending on x7, resolved by writeback
    pset(7);
    cyc();
    bus.A1D = 5'd7;
    #3;
    chk("stall_on_pending", bus.StallD, 1);
    chk("count_one", bus.PendCount, 1);
    cyc();
    bus.A1D = 5'd7;
    wr(7, 32'h0000_0055);
    #3;
    chk("stall_released_by_wb", bus.StallD, 0);
    chk("wb_bypass_rd1", bus.RD1D, 32'h0000_0055);
    cyc();
    bus.A1D = 5'd7;
    #3;
    chk("count_after_wb", bus.PendCount, 0);
    chk("x7_stored", bus.RD1D, 32'h0000_0055);
    cyc();

    // Set and clear of x9 in one cycle: set wins
    pset(9);
    cyc();
    pset(9);
    wr(9, 32'h0000_0099);
    cyc();
    bus.A2D = 5'd9;
    #3;
    chk("set_beats_clear_count", bus.PendCount, 1);
    chk("set_beats_clear_stall", bus.StallD, 1);
    cyc();
    wr(9, 32'h0000_0100);
    cyc();
    #3 chk("x9_cleared", bus.PendCount, 0);
    cyc();

    // Flush of the previous issue
    pset(3);
    cyc();
    bus.FlushE = 1'b1;
    cyc();
    bus.A1D = 5'd3;
    #3;
    chk("flush_stall", bus.StallD, 0);
    chk("flush_count", bus.PendCount, 0);
    cyc();

    // Flush while the same index is re-issued keeps it pending
    pset(3);
    cyc();
    bus.FlushE = 1'b1;
    pset(3);
    cyc();
    bus.A1D = 5'd3;
    #3 chk("flush_same_reissue", bus.PendCount, 1);
    bus.FlushE = 1'b1;
    cyc();
    #3 chk("flush_reissued", bus.PendCount, 0);
    cyc();

    // Flush clears only the most recent issue
    pset(10);
    cyc();
    pset(11);
    cyc();
    bus.FlushE = 1'b1;
    cyc();
    bus.A1D = 5'd10;
    bus.A2D = 5'd11;
    #3;
    chk("flush_keeps_older", bus.PendCount, 1);
    chk("older_still_stalls", bus.StallD, 1);
    cyc();
    wr(10, 32'h0000_0010);
    cyc();

    // Reset mid-load discards pending state and register contents
    wr(4, 32'h0000_DEAD);
    cyc();
    pset(4);
    cyc();
    pset(8);
    cyc();
    bus.A1D = 5'd4;
    bus.A2D = 5'd8;
    #3;
    chk("two_pending", bus.PendCount, 2);
    chk("x4_before_reset", bus.RD1D, 32'h0000_DEAD);
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", bus.PendCount, 0);
    chk("async_reset_stall", bus.StallD, 0);
    chk("async_reset_x4", bus.RD1D, 0);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    bus.A1D = 5'd4;
    #3;
    chk("x4_after_release", bus.RD1D, 0);
    chk("count_after_release", bus.PendCount, 0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port RegWriteW, input, 1, writeback write enable.
REQ-006 SHALL have port RdW, input, ADDR_W, writeback destination index.
REQ-007 SHALL have port ResultW, input, DATA_W, writeback result data.
REQ-008 SHALL have ports A1D and A2D, input, ADDR_W each, decode source indices.
REQ-009 SHALL have ports RD1D and RD2D, output, DATA_W each, decode read data.
REQ-010 SHALL have port PendSetD, input, 1, asserted when decode issues a late-result (load) instruction.
REQ-011 SHALL have port RdD, input, ADDR_W, destination of the issuing instruction.
REQ-012 SHALL have port FlushE, input, 1, squash of the instruction issued in the previous cycle.
REQ-013 SHALL have port StallD, output, 1, decode must hold because a source is pending.
REQ-014 SHALL have port PendCount, output, ADDR_W+1, number of pending registers.

Function
REQ-015 SHALL store 2**ADDR_W registers; register 0 SHALL read 0, ignore writes, and never be marked pending.
REQ-016 SHALL write ResultW into register RdW on the clock edge when RegWriteW=1 and RdW!=0.
REQ-017 SHALL drive RD1D/RD2D combinationally: 0 if the index is 0; ResultW if RegWriteW=1 and RdW equals the index (same-cycle bypass); otherwise the stored value.
REQ-018 SHALL hold one pending bit per register; PendSetD=1 with RdD!=0 SHALL set bit RdD at the edge.
REQ-019 SHALL clear pending bit RdW at the edge when RegWriteW=1.
REQ-020 SHALL, when the same index is set and cleared in one cycle, leave the bit set (newer issue wins).
REQ-021 SHALL record the index set in each cycle (LastSet valid + index); FlushE=1 SHALL clear that bit at the edge, unless the same index is being set this cycle.
REQ-022 SHALL assert StallD combinationally when A1D or A2D is nonzero, its pending bit is 1, and it is not being cleared by RegWriteW/RdW in the same cycle.
REQ-023 SHALL drive PendCount as a register equal to the population of pending bits after each edge; it never exceeds 2**ADDR_W-1.
REQ-024 SHALL be read-latency 0 (combinational) and write-latency 1 cycle.

Reset
REQ-025 SHALL, on rst_n low, immediately clear all registers to 0, all pending bits, LastSet valid, and PendCount.
REQ-026 SHALL drive StallD=0, RD1D=RD2D=0 for zero indices, PendCount=0 while in reset.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-load discards pending state without a writeback.

Structure
REQ-028 SHALL take DATA_W/ADDR_W defaults and the register-0 index constant from the shared pipeline package.
REQ-029 SHALL contain one natural sub-module, pending_table, holding pending bits, LastSet, and PendCount; storage and bypass stay in the top.

Verification
REQ-030 Write x5=0x0000_00AA, next cycle A1D=5 -> RD1D=0x0000_00AA; same-cycle write x6=0x1234 with A2D=6 -> RD2D=0x1234.
REQ-031 Write x0=0xFFFF_FFFF, A1D=0 -> RD1D=0; PendSetD with RdD=0 -> StallD stays 0, PendCount=0.
REQ-032 PendSetD RdD=7, next cycle A1D=7 -> StallD=1, PendCount=1; RegWriteW RdW=7 ResultW=0x55 -> StallD=0 that cycle, RD1D=0x55, PendCount=0 next.
REQ-033 Pending x9, same cycle PendSetD RdD=9 and RegWriteW RdW=9 -> bit stays set, PendCount=1.
REQ-034 PendSetD RdD=3, next cycle FlushE=1 -> bit 3 clear, PendCount=0, A1D=3 -> StallD=0.
REQ-035 Pending x4 and x8, rst_n low mid-cycle -> PendCount=0 and StallD=0 immediately; x4 reads 0 after release.
